// File: rtl/wisc_fetch_unit.sv
// ---------------------------------------------------------------------------
// wisc_fetch_unit
//   Instruction fetch and PC sequencing for the 16-bit WISC single-cycle core.
//   Fetches one word at a time over a req/ack handshake, presents it to the
//   decoder for exactly one EXEC cycle, then computes the next PC from the
//   decoder's halt/branch outputs, the flags and the register operand.
//
// Ports
//   clk, rst_n           core clock, asynchronous active-low reset
//   imem_req/addr        fetch request (held until ack) and byte address (= pc)
//   imem_ack/rdata       acknowledge with same-cycle instruction word
//   instr, instr_valid   latched instruction and its single-cycle valid
//   pc, pc_plus2         current instruction address and pc + 2
//   halt, BEn, Br        decoder sequencing controls
//   flags                {Z, V, N}
//   br_target_reg        rs contents for register branches
//   halted               core stopped until reset
// ---------------------------------------------------------------------------
module wisc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  input  logic        halt,
  input  logic        BEn,
  input  logic        Br,
  input  logic [2:0]  flags,
  input  logic [15:0] br_target_reg,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] instr_q;
  logic        req_q;
  logic        valid_q;
  logic        halted_q;

  logic        flag_z, flag_v, flag_n;
  logic        cond_met;
  logic [15:0] pc_plus2_w;
  logic [15:0] br_offset;
  logic [15:0] br_target;
  logic [15:0] pc_d;

  assign flag_z     = flags[2];
  assign flag_v     = flags[1];
  assign flag_n     = flags[0];
  assign pc_plus2_w = pc_q + 16'd2;

  // Condition code evaluation for the latched branch instruction.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cond_met = 1'b0;
    unique case (instr_q[11:9])
      3'b000: cond_met = !flag_z;
      3'b001: cond_met = flag_z;
      3'b010: cond_met = !flag_z && !flag_n;
      3'b011: cond_met = flag_n;
      3'b100: cond_met = flag_z || (!flag_z && !flag_n);
      3'b101: cond_met = flag_n || flag_z;
      3'b110: cond_met = flag_v;
      3'b111: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  // Sign-extended 9-bit word offset scaled to bytes; the bit shifted out of
  // the top is dropped, matching a 16-bit wrapping add.
  assign br_offset = {{6{instr_q[8]}}, instr_q[8:0], 1'b0};

  // Register branches force bit 0 low so the target is always word aligned.
  assign br_target = Br ? (br_target_reg & 16'hFFFE) : (pc_plus2_w + br_offset);
  assign pc_d      = (BEn && cond_met) ? br_target : pc_plus2_w;

  // Single sequencing FSM; outputs are registered alongside the state so
  // they change only on clock edges (and drop immediately on reset).
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= 16'h0000;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          // Address is pc_q, which does not move while waiting for ack.
          if (imem_ack) begin
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          valid_q <= 1'b0;
          // halt has priority over any branch; pc keeps pointing at HLT.
          if (halt) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else begin
            pc_q    <= pc_d;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus2    = pc_plus2_w;
  assign halted      = halted_q;

endmodule
